// File: rtl/serial_digit_sub.sv
// serial_digit_sub: digit-serial subtractor, diff = x - y - bin (mod 2^WIDTH).
// Each clock it retires one 2-bit digit, LSB digit first, through a single
// 2-bit borrow cell. An operation takes STEPS = WIDTH/2 RUN cycles.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   producer presents an operand set
//   in_ready   block can accept (IDLE and not in reset)
//   in_x       minuend
//   in_y       subtrahend
//   in_bin     borrow-in
//   out_valid  result available (held until out_ready)
//   out_ready  consumer accepts result
//   out_diff   difference, modulo 2^WIDTH
//   out_bout   borrow-out, 1 iff x < y + bin
module serial_digit_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout
);

  localparam int STEPS = WIDTH / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_x_sr, r_y_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic [2:0]       w_t;
  logic [WIDTH-1:0] w_word;
  logic             w_accept, w_step, w_last;

  assign in_ready = (r_state == IDLE) & ~rst;
  assign w_accept = in_valid & in_ready;
  assign w_step   = (r_state == RUN);
  assign w_last   = w_step & (r_cnt == LAST);

  // 2-bit borrow cell: t[2] is the borrow out of this digit.
  assign w_t = {1'b0, r_x_sr[1:0]} - {1'b0, r_y_sr[1:0]} - {2'b00, r_br};

  // Result shift register holds only the already-finished digits; the digit
  // computed in the final RUN cycle is concatenated on top directly.
  generate
    if (WIDTH >= 6) begin : g_res_wide
      logic [WIDTH-1:2] r_res_sr;
      always_ff @(posedge clk) begin
        if (rst)         r_res_sr <= '0;
        else if (w_step) r_res_sr <= {w_t[1:0], r_res_sr[WIDTH-1:4]};
      end
      assign w_word = {w_t[1:0], r_res_sr};
    end else if (WIDTH == 4) begin : g_res_4
      logic [1:0] r_res_sr;
      always_ff @(posedge clk) begin
        if (rst)         r_res_sr <= '0;
        else if (w_step) r_res_sr <= w_t[1:0];
      end
      assign w_word = {w_t[1:0], r_res_sr};
    end else begin : g_res_2
      assign w_word = w_t[1:0];
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_sr    <= '0;
      r_y_sr    <= '0;
      r_cnt     <= '0;
      r_br      <= 1'b0;
      out_valid <= 1'b0;
      out_diff  <= '0;
      out_bout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x_sr <= in_x;
        r_y_sr <= in_y;
        r_br   <= in_bin;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_x_sr <= r_x_sr >> 2;
        r_y_sr <= r_y_sr >> 2;
        r_br   <= w_t[2];
        r_cnt  <= r_cnt + CW'(1);
      end
      if (w_last) begin
        out_diff  <= w_word;
        out_bout  <= w_t[2];
        out_valid <= 1'b1;
      end else if (r_state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_digit_sub.sv
module tb_serial_digit_sub;
  localparam int W = 8;
  localparam int S = W / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_bin, out_ready;
  logic         in_ready, out_valid, out_bout;
  logic [W-1:0] in_x, in_y, out_diff;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_hs  = 0;

  always #5 clk = ~clk;

  serial_digit_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_bout(out_bout)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)   n_acc++;
      if (out_valid && out_ready) n_hs++;
    end
  end

  typedef struct {
    logic [W-1:0] x, y;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    int           hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE. hold>0: keep out_ready low for hold cycles
  // after out_valid and drive junk operands with in_valid while busy.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                       input logic [W-1:0] ed, input logic eb, input int hold);
    int lat;
    chk("in_ready_idle", in_ready, 1);
    in_x = x; in_y = y; in_bin = bin; in_valid = 1'b1;
    out_ready = (hold == 0);
    tick;
    if (hold > 0) begin
      in_x = ~x; in_y = x ^ y; in_bin = ~bin;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("busy_in_ready", in_ready, 0);
      tick;
      lat++;
    end
    chk("latency", lat, S);
    chk("diff", out_diff, ed);
    chk("bout", out_bout, eb);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", out_valid, 1);
      chk("hold_diff", out_diff, ed);
      chk("hold_bout", out_bout, eb);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("valid_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
    chk("diff_kept", out_diff, ed);
  endtask

  vec_t vecs[7];

  initial begin
    logic [W:0]   ref_v;
    logic [W-1:0] rx, ry;
    logic         rb;
    int           n;

    vecs[0] = '{x:8'h5A, y:8'h3C, bin:1'b0, d:8'h1E, bo:1'b0, hold:0};
    vecs[1] = '{x:8'h00, y:8'h01, bin:1'b0, d:8'hFF, bo:1'b1, hold:0};
    vecs[2] = '{x:8'h00, y:8'h00, bin:1'b1, d:8'hFF, bo:1'b1, hold:0};
    vecs[3] = '{x:8'hFF, y:8'hFF, bin:1'b1, d:8'hFF, bo:1'b1, hold:0};
    vecs[4] = '{x:8'h80, y:8'h7F, bin:1'b0, d:8'h01, bo:1'b0, hold:0};
    vecs[5] = '{x:8'hC3, y:8'h47, bin:1'b1, d:8'h7B, bo:1'b0, hold:5};
    vecs[6] = '{x:8'h01, y:8'h02, bin:1'b1, d:8'hFE, bo:1'b1, hold:0};

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_bin = 1'b0; out_ready = 1'b1;
    tick; tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_diff", out_diff, 0);
    chk("rst_bout", out_bout, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].x, vecs[i].y, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].hold);

    // Reset during the second RUN cycle aborts the operation.
    in_x = 8'hAA; in_y = 8'h11; in_bin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("rst_comb_in_ready", in_ready, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (out_valid) n++;
    end
    chk("abort_no_pulse", n, 0);
    do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0);

    // Random sweep against the arithmetic reference.
    for (int k = 0; k < 2000; k++) begin
      rx = W'($urandom); ry = W'($urandom); rb = 1'($urandom);
      ref_v = {1'b0, rx} - {1'b0, ry} - {{W{1'b0}}, rb};
      in_x = rx; in_y = ry; in_bin = rb; in_valid = 1'b1;
      out_ready = 1'($urandom);
      tick;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        out_ready = 1'($urandom);
        tick;
        n++;
      end
      chk("rnd_latency", n, S);
      chk("rnd_diff", out_diff, ref_v[W-1:0]);
      chk("rnd_bout", out_bout, ref_v[W]);
      n = $urandom_range(0, 3);
      out_ready = 1'b0;
      for (int j = 0; j < n; j++) begin
        tick;
        chk("rnd_hold", {out_valid, out_bout, out_diff}, {1'b1, ref_v[W], ref_v[W-1:0]});
      end
      out_ready = 1'b1;
      tick;
      chk("rnd_drop", out_valid, 0);
    end

    // The aborted operation was the only accept without a result.
    chk("one_result_per_accept", n_hs, n_acc - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
